// File: rtl/keypad_scan_if.sv
// Keypad pins and decoded-key outputs of keypad_scan, plus the scanner's state for observation.
// State encoding on `state`: 0 = scan, 1 = debounce, 2 = pressed.
interface keypad_scan_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_validn;
  logic [1:0] state;

  modport master (input row_n, output col_n, output key_code, output key_validn, output state);
  modport slave  (output row_n, input col_n, input key_code, input key_validn, input state);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with press/release debounce and key encoding.
// Optional build macro KEYPAD_GHOST_REJECT_EN: multi-row samples are treated as no key.
module keypad_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic          clk,
  input  logic          resetn,
  keypad_scan_if.master bus
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, PRESSED = 2'd2} state_t;

  state_t        state;
  logic [3:0]    row_meta;
  logic [3:0]    row_s;
  logic [1:0]    col;
  logic [1:0]    row;
  logic [DW-1:0] dwell;
  logic [BW-1:0] cnt;
  logic [3:0]    col_n;
  logic [3:0]    key_code;
  logic          key_validn;
  logic [1:0]    low_row;
  logic [1:0]    next_col;
  logic          hit;
  logic          match;
`ifdef KEYPAD_GHOST_REJECT_EN
  logic [3:0]    pat;
`endif

  function automatic logic [3:0] encode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Lowest-index low row wins when several rows are closed.
  always_comb begin
    low_row = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s[i]) low_row = 2'(i);
    end
  end

  assign next_col = col + 2'd1;

`ifdef KEYPAD_GHOST_REJECT_EN
  assign hit   = $onehot(~row_s);
  assign match = (row_s == pat);
`else
  assign hit   = ~&row_s;
  assign match = ~row_s[row];
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= SCAN;
      row_meta   <= 4'hF;
      row_s      <= 4'hF;
      col        <= 2'd0;
      row        <= 2'd0;
      dwell      <= '0;
      cnt        <= '0;
      col_n      <= 4'b1110;
      key_code   <= 4'h0;
      key_validn <= 1'b1;
`ifdef KEYPAD_GHOST_REJECT_EN
      pat        <= 4'hF;
`endif
    end else begin
      row_meta <= bus.row_n;
      row_s    <= row_meta;
      case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (hit) begin
              row   <= low_row;
              cnt   <= '0;
              state <= DEBOUNCE;
`ifdef KEYPAD_GHOST_REJECT_EN
              pat   <= row_s;
`endif
            end else begin
              col   <= next_col;
              col_n <= ~(4'b0001 << next_col);
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        DEBOUNCE: begin
          // A bounce drops back to scanning the same column from a fresh dwell.
          if (!match) begin
            state <= SCAN;
            dwell <= '0;
          end else if (cnt == DEB_LAST) begin
            key_code   <= encode(row, col);
            key_validn <= 1'b0;
            cnt        <= '0;
            state      <= PRESSED;
          end else begin
            cnt <= cnt + BW'(1);
          end
        end
        PRESSED: begin
          if (!row_s[row]) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            key_validn <= 1'b1;
            cnt        <= '0;
            dwell      <= '0;
            col        <= next_col;
            col_n      <= ~(4'b0001 << next_col);
            state      <= SCAN;
          end else begin
            cnt <= cnt + BW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  assign bus.col_n      = col_n;
  assign bus.key_code   = key_code;
  assign bus.key_validn = key_validn;
  assign bus.state      = state;
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=8 and a modelled 4x4 key matrix.
// Cycle index k counts rising edges since reset release; checks are taken on the falling edge.
module tb_keypad_scan;
  logic        clk;
  logic        resetn;
  logic [15:0] keys;
  int          k;
  int          vec_cnt;
  int          err_cnt;
  logic [3:0]  exp_q[$];

  keypad_scan_if bus ();

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A closed key pulls its row low only while its column is driven low.
  always_comb begin
    bus.row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !bus.col_n[c]) bus.row_n[r] = 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  // Scoreboard: every accepted press must deliver the next queued code.
  always @(negedge bus.key_validn) begin
    #1;
    chk("press_pending", 8'(exp_q.size() != 0), 8'd1);
    if (exp_q.size() != 0) chk("press_code", bus.key_code, exp_q.pop_front());
  end

  // ---------------- drivers ----------------
  task automatic goto(input int t);
    while (k < t) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("rst_col", bus.col_n, 4'b1110);
    chk("rst_valid", bus.key_validn, 1'b1);
    chk("rst_code", bus.key_code, 4'h0);
    chk("rst_state", bus.state, 2'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    k = 0;
  endtask

  task automatic press(input int r, input int c);
    keys[r*4+c] = 1'b1;
  endtask

  task automatic release_key(input int r, input int c);
    keys[r*4+c] = 1'b0;
  endtask

  logic [3:0] exp_col;

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    k       = 0;
    keys    = '0;
    resetn  = 1'b1;
    #1;

    // Idle scan: column advances every 4 cycles, no key reported.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      goto(i);
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      chk("idle_col", bus.col_n, exp_col);
      chk("idle_valid", bus.key_validn, 1'b1);
    end

    // Key '6' (r1,c2): detected at edge 12, valid at 20; released at 40, row_s high at 42, valid rises at 50.
    do_reset();
    press(1, 2);
    exp_q.push_back(4'h6);
    goto(19);
    chk("k6_valid_pre", bus.key_validn, 1'b1);
    chk("k6_col_held", bus.col_n, 4'b1011);
    goto(20);
    chk("k6_valid", bus.key_validn, 1'b0);
    chk("k6_code", bus.key_code, 4'h6);
    goto(40);
    release_key(1, 2);
    goto(49);
    chk("k6_rel_pre", bus.key_validn, 1'b0);
    goto(50);
    chk("k6_rel", bus.key_validn, 1'b1);
    chk("k6_next_col", bus.col_n, 4'b0111);
    chk("k6_code_hold", bus.key_code, 4'h6);

    // '#' then '*': two separate low pulses with codes F then E.
    do_reset();
    press(3, 2);
    exp_q.push_back(4'hF);
    goto(20);
    chk("hash_valid", bus.key_validn, 1'b0);
    chk("hash_code", bus.key_code, 4'hF);
    goto(30);
    release_key(3, 2);
    goto(39);
    chk("hash_rel_pre", bus.key_validn, 1'b0);
    goto(40);
    chk("hash_rel", bus.key_validn, 1'b1);
    press(3, 0);
    exp_q.push_back(4'hE);
    goto(45);
    chk("gap_valid", bus.key_validn, 1'b1);
    chk("gap_code", bus.key_code, 4'hF);
    goto(55);
    chk("star_valid_pre", bus.key_validn, 1'b1);
    goto(56);
    chk("star_valid", bus.key_validn, 1'b0);
    chk("star_code", bus.key_code, 4'hE);
    goto(60);
    release_key(3, 0);
    goto(69);
    chk("star_rel_pre", bus.key_validn, 1'b0);
    goto(70);
    chk("star_rel", bus.key_validn, 1'b1);

    // 3-cycle glitch on r0/c0: debounce aborts at edge 6, column 0 rescanned until edge 10.
    do_reset();
    press(0, 0);
    goto(3);
    release_key(0, 0);
    for (int i = 3; i <= 20; i++) begin
      goto(i);
      chk("glitch_valid", bus.key_validn, 1'b1);
      if (i == 9) chk("glitch_col0", bus.col_n, 4'b1110);
      if (i == 10) chk("glitch_col1", bus.col_n, 4'b1101);
    end

    // Rows 0 and 2 low on column 1.
    do_reset();
    press(0, 1);
    press(2, 1);
`ifdef KEYPAD_GHOST_REJECT_EN
    exp_col = 4'b1011;
`else
    exp_col = 4'b1101;
    exp_q.push_back(4'h2);
`endif
    goto(8);
    chk("ghost_col", bus.col_n, exp_col);
    goto(15);
    chk("ghost_valid_pre", bus.key_validn, 1'b1);
    goto(16);
`ifdef KEYPAD_GHOST_REJECT_EN
    chk("ghost_valid", bus.key_validn, 1'b1);
`else
    chk("ghost_valid", bus.key_validn, 1'b0);
    chk("ghost_code", bus.key_code, 4'h2);
`endif
    goto(20);
    release_key(0, 1);
    release_key(2, 1);
    goto(30);
    chk("ghost_rel", bus.key_validn, 1'b1);

    // Reset while a key is held: valid clears at once, then the held key re-debounces.
    do_reset();
    press(1, 2);
    exp_q.push_back(4'h6);
    goto(25);
    chk("mid_valid", bus.key_validn, 1'b0);
    do_reset();
    exp_q.push_back(4'h6);
    goto(19);
    chk("re_valid_pre", bus.key_validn, 1'b1);
    goto(20);
    chk("re_valid", bus.key_validn, 1'b0);
    chk("re_code", bus.key_code, 4'h6);
    release_key(1, 2);
    goto(30);
    chk("re_rel", bus.key_validn, 1'b1);

    // ---------------- report ----------------
    goto(32);
    chk("exp_q_empty", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
